// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - EX-stage divider request/result bundle
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  busy_o;

  // EX stage side: issues the operation and watches for the result
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  // Divider side
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring 32-bit signed/unsigned divider
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  // Number of restoring steps; the counter must be able to reach it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;        // partial remainder
  logic [DATA_W-1:0]   quo_q, quo_d;        // dividend shifts out, quotient shifts in
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                signed_q, signed_d;
  logic                sign1_q, sign1_d;    // dividend was negative
  logic                sign2_q, sign2_d;    // divisor was negative
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W:0]     shifted;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   op1_abs, op2_abs;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  // Operand magnitudes, one trial subtraction and final sign fix-up
  always_comb begin
    op1_abs = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    op2_abs = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;
    // Remainder stays below the divisor, so bit DATA_W of the difference is its sign.
    shifted = {rem_q, quo_q[DATA_W-1]};
    diff    = shifted - {1'b0, divisor_q};
    quo_fix = (signed_q && (sign1_q ^ sign2_q)) ? -quo_q : quo_q;
    rem_fix = (signed_q && sign1_q) ? -rem_q : rem_q;
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    signed_d  = signed_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = BYZERO;
          end else begin
            state_d   = ON;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = op1_abs;
            divisor_d = op2_abs;
            signed_d  = bus.signed_div_i;
            sign1_d   = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
            sign2_d   = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
          end
        end
      end

      BYZERO: begin
        if (bus.annul_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          state_d  = END;
          ready_d  = 1'b1;
          result_d = '0;
        end
      end

      ON: begin
        if (bus.annul_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q != CNT_LAST) begin
          rem_d = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d  = END;
          ready_d  = 1'b1;
          result_d = {rem_fix, quo_fix};
        end
      end

      END: begin
        // Hold the result until EX drops its request.
        if (!bus.start_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end

      default: begin
        state_d  = FREE;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = (state_q == BYZERO) || (state_q == ON);

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Truncating division: quotient toward zero, remainder follows dividend.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction-level reference: idle, computing for a fixed count, done.
  int          m_phase = 0;
  int          m_left  = 0;
  logic [63:0] m_res   = 64'd0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (rst) begin
      m_phase <= 0;
      m_left  <= 0;
      m_res   <= 64'd0;
    end else begin
      case (m_phase)
        0: if (bus.start_i && !bus.annul_i) begin
             m_phase <= 1;
             m_left  <= (bus.opdata2_i == 32'd0) ? 1 : 33;
             m_res   <= ref_div(bus.opdata1_i, bus.opdata2_i, bus.signed_div_i);
           end
        1: if (bus.annul_i) m_phase <= 0;
           else if (m_left == 1) m_phase <= 2;
           else m_left <= m_left - 1;
        2: if (!bus.start_i) m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_ready", 64'(bus.ready_o), 64'(m_phase == 2));
      check("cyc_busy",  64'(bus.busy_o),  64'(m_phase == 1));
      check("cyc_result", bus.result_o, (m_phase == 2) ? m_res : 64'd0);
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = s;
  endtask

  // Edges counted from the start edge until ready_o is seen.
  task automatic wait_ready(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    while (edges < 100) begin
      @(posedge clk);
      #2;
      edges++;
      if (bus.busy_o) busy_cycles++;
      if (bus.ready_o) break;
    end
    if (!bus.ready_o) begin
      checks++;
      failures++;
      $display("FAIL wait_ready timeout actual=no_ready required=ready");
    end
  endtask

  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp, input int exp_edges,
                          input int exp_busy);
    int e, bc;
    @(posedge clk);
    #2;
    drive(a, b, s);
    bus.start_i = 1'b1;
    wait_ready(e, bc);
    check({name, "_latency"}, 64'(e), 64'(exp_edges));
    check({name, "_result"}, bus.result_o, exp);
    if (exp_busy >= 0) check({name, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
    drive(32'hDEAD_BEEF, 32'h1234_5678, ~s);
    @(posedge clk);
    #2;
    check({name, "_held"}, bus.result_o, exp);
    bus.start_i = 1'b0;
    @(posedge clk);
    #2;
    check({name, "_free_ready"}, 64'(bus.ready_o), 64'd0);
    check({name, "_free_result"}, bus.result_o, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_op();
    bit done, aborted;
    drive(pick(), pick(), 1'($urandom_range(0, 1)));
    bus.start_i = 1'b1;
    if ($urandom_range(0, 7) == 0) begin
      bus.annul_i = 1'b1;
      @(posedge clk);
      #2;
      bus.annul_i = 1'b0;
    end
    done = 1'b0;
    aborted = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      @(posedge clk);
      #2;
      if (bus.ready_o) begin
        done = 1'b1;
      end else begin
        drive(pick(), pick(), 1'($urandom_range(0, 1)));
        if (bus.busy_o && $urandom_range(0, 49) == 0) begin
          bus.annul_i = 1'b1;
          bus.start_i = 1'b0;
          @(posedge clk);
          #2;
          bus.annul_i = 1'b0;
          done = 1'b1;
          aborted = 1'b1;
        end
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL rand_op timeout actual=no_ready required=ready");
    end
    if (!aborted) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #2;
        drive(pick(), pick(), 1'($urandom_range(0, 1)));
      end
      bus.start_i = 1'b0;
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e, bc, rc;
    rst          = 1'b1;
    bus.start_i  = 1'b0;
    bus.annul_i  = 1'b0;
    drive(32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("reset_ready",  64'(bus.ready_o), 64'd0);
    check("reset_busy",   64'(bus.busy_o),  64'd0);
    check("reset_result", bus.result_o,     64'd0);
    rst = 1'b0;

    check("pin_100_7",   ref_div(32'd100, 32'd7, 1'b0),                64'h00000002_0000000E);
    check("pin_m7_2",    ref_div(32'hFFFF_FFF9, 32'd2, 1'b1),          64'hFFFFFFFF_FFFFFFFD);
    check("pin_u_ffff",  ref_div(32'hFFFF_FFFF, 32'h10, 1'b0),         64'h0000000F_0FFFFFFF);
    check("pin_ovf",     ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1),  64'h00000000_80000000);

    directed("u100_7",  32'd100,       32'd7,         1'b0, 64'h00000002_0000000E, 34, 33);
    directed("s_m7_2",  32'hFFFF_FFF9, 32'd2,         1'b1, 64'hFFFFFFFF_FFFFFFFD, 34, -1);
    directed("u_ffff",  32'hFFFF_FFFF, 32'h10,        1'b0, 64'h0000000F_0FFFFFFF, 34, -1);
    directed("byzero",  32'd12345,     32'd0,         1'b1, 64'd0,                 2,  1);
    directed("s_ovf",   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, 34, -1);

    // Flush at cnt=10, then a fresh 3/3.
    @(posedge clk);
    #2;
    drive(32'd5000, 32'd3, 1'b0);
    bus.start_i = 1'b1;
    repeat (11) @(posedge clk);
    #2;
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #2;
    bus.annul_i = 1'b0;
    rc = 0;
    repeat (40) begin
      @(posedge clk);
      #2;
      if (bus.ready_o) rc++;
    end
    check("annul_no_ready", 64'(rc), 64'd0);
    directed("after_annul", 32'd3, 32'd3, 1'b0, 64'h00000000_00000001, 34, 33);

    // Reset in the middle of an operation with start still held.
    @(posedge clk);
    #2;
    drive(32'd777, 32'd5, 1'b0);
    bus.start_i = 1'b1;
    repeat (21) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("rst_mid_ready",  64'(bus.ready_o), 64'd0);
    check("rst_mid_busy",   64'(bus.busy_o),  64'd0);
    check("rst_mid_result", bus.result_o,     64'd0);
    rst = 1'b0;
    wait_ready(e, bc);
    check("rst_restart_latency", 64'(e), 64'd34);
    check("rst_restart_result", bus.result_o, 64'h00000002_0000009B);
    bus.start_i = 1'b0;
    @(posedge clk);
    #2;

    for (int i = 0; i < 150; i++) rand_op();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
